hp_alarm_mgr: RTL and testbench

//  Downstream consumer of N hoggephase phase-detector Alarm outputs.
//  - Registers the alarms and edge-detects them into glitch events.
//  - Qualifies events against a threshold within a time window, and also detects a stuck alarm.
//  - Raises a sticky FAULT plus a one-cycle IRQ, and keeps a saturating event count for the

---
 rtl/hp_alarm_mgr.sv | 190 +++++++++++++++++++
 tb/tb_hp_alarm_mgr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_alarm_mgr.sv
// Alarm manager for hoggephase phase-detector outputs: edge-detects alarms, qualifies
// bursts inside a time window or a stuck level, and raises a sticky FAULT with a one-cycle IRQ.
module hp_alarm_mgr #(
    parameter int N       = 2,
    parameter int THRESH  = 2,
    parameter int WINDOW  = 16,
    parameter int ARM_DLY = 8,
    parameter int CW      = 16
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          ARM,
    input  logic          CLR,
    input  logic [N-1:0]  ALARM_IN,
    output logic          FAULT,
    output logic [N-1:0]  FAULT_SRC,
    output logic          IRQ,
    output logic [CW-1:0] EVT_CNT,
    output logic [1:0]    STATE
);

    localparam int DW = $clog2(ARM_DLY + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int SW = $clog2(WINDOW);
    localparam int EW = $clog2(THRESH + 1);

    localparam logic [DW-1:0] DLY_INIT  = DW'(ARM_DLY - 1);
    localparam logic [WW-1:0] WIN_INIT  = WW'(WINDOW - 1);
    localparam logic [SW-1:0] STUCK_LIM = SW'(WINDOW - 1);
    localparam logic [EW-1:0] ETH       = EW'(THRESH);

    typedef enum logic [1:0] {
        S_DIS    = 2'd0,
        S_ARMING = 2'd1,
        S_MON    = 2'd2,
        S_FLT    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic [N-1:0]  src_q, src_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          fault_q, fault_d;
    logic [N-1:0]  fsrc_q, fsrc_d;
    logic          irq_q, irq_d;
    logic [CW-1:0] evt_q, evt_d;
    logic [N-1:0]  a_q, a_dly_q;

    logic [N-1:0]  ev_vec;
    logic          ev_any;
    logic          win_open;
    logic [SW-1:0] scnt_inc;
    logic          stuck;
    logic          hit;

    assign ev_vec   = a_q & ~a_dly_q;
    assign ev_any   = |ev_vec;
    assign win_open = (ecnt_q != '0);
    assign scnt_inc = scnt_q + 1'b1;
    assign stuck    = (|a_q) && (scnt_inc >= STUCK_LIM);

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        wcnt_d  = wcnt_q;
        ecnt_d  = ecnt_q;
        src_d   = src_q;
        scnt_d  = scnt_q;
        fault_d = fault_q;
        fsrc_d  = fsrc_q;
        irq_d   = 1'b0;
        evt_d   = evt_q;
        hit     = 1'b0;

        case (state_q)
            S_DIS: begin
                if (ARM) begin
                    state_d = S_ARMING;
                    dly_d   = DLY_INIT;
                end
            end
            S_ARMING: begin
                if (!ARM)
                    state_d = S_DIS;
                else if (dly_q == '0)
                    state_d = S_MON;
                else
                    dly_d = dly_q - 1'b1;
            end
            S_MON: begin
                if (!ARM) begin
                    state_d = S_DIS;
                    wcnt_d  = '0;
                    ecnt_d  = '0;
                    src_d   = '0;
                    scnt_d  = '0;
                end else begin
                    // an event on the expiry cycle falls through and starts a fresh window
                    if (win_open && wcnt_q != '0) begin
                        wcnt_d = wcnt_q - 1'b1;
                        if (ev_any) begin
                            ecnt_d = ecnt_q + 1'b1;
                            src_d  = src_q | ev_vec;
                        end
                    end else if (ev_any) begin
                        wcnt_d = WIN_INIT;
                        ecnt_d = EW'(1);
                        src_d  = ev_vec;
                    end else begin
                        wcnt_d = '0;
                        ecnt_d = '0;
                        src_d  = '0;
                    end

                    scnt_d = (|a_q) ? scnt_inc : '0;
                    hit    = (ecnt_d >= ETH);

                    if (ev_any && evt_q != {CW{1'b1}})
                        evt_d = evt_q + 1'b1;

                    if (hit || stuck) begin
                        state_d = S_FLT;
                        fault_d = 1'b1;
                        irq_d   = 1'b1;
                        fsrc_d  = stuck ? a_q : src_d;
                        wcnt_d  = '0;
                        ecnt_d  = '0;
                        src_d   = '0;
                        scnt_d  = '0;
                    end
                end
            end
            S_FLT: begin
                if (CLR) begin
                    fault_d = 1'b0;
                    fsrc_d  = '0;
                    if (ARM) begin
                        state_d = S_ARMING;
                        dly_d   = DLY_INIT;
                    end else begin
                        state_d = S_DIS;
                    end
                end
            end
            default: state_d = S_DIS;
        endcase

        if (CLR)
            evt_d = '0;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= S_DIS;
            dly_q   <= '0;
            wcnt_q  <= '0;
            ecnt_q  <= '0;
            src_q   <= '0;
            scnt_q  <= '0;
            fault_q <= 1'b0;
            fsrc_q  <= '0;
            irq_q   <= 1'b0;
            evt_q   <= '0;
            a_q     <= '0;
            a_dly_q <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            wcnt_q  <= wcnt_d;
            ecnt_q  <= ecnt_d;
            src_q   <= src_d;
            scnt_q  <= scnt_d;
            fault_q <= fault_d;
            fsrc_q  <= fsrc_d;
            irq_q   <= irq_d;
            evt_q   <= evt_d;
            a_q     <= ALARM_IN;
            a_dly_q <= a_q;
        end
    end

    assign FAULT     = fault_q;
    assign FAULT_SRC = fsrc_q;
    assign IRQ       = irq_q;
    assign EVT_CNT   = evt_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_hp_alarm_mgr.sv
// Bench for hp_alarm_mgr: two instances (default and CW=2/THRESH=15) tracked every cycle
// by a timestamp-based reference model, plus directed checks of the headline scenarios.
module tb_hp_alarm_mgr;

    logic        CK, RST, ARM, CLR;
    logic [1:0]  ALARM_IN;
    logic        FAULT1, IRQ1, FAULT2, IRQ2;
    logic [1:0]  FSRC1, FSRC2, STATE1, STATE2;
    logic [15:0] CNT1;
    logic [1:0]  CNT2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    hp_alarm_mgr u1 (
        .CK(CK), .RST(RST), .ARM(ARM), .CLR(CLR), .ALARM_IN(ALARM_IN),
        .FAULT(FAULT1), .FAULT_SRC(FSRC1), .IRQ(IRQ1), .EVT_CNT(CNT1), .STATE(STATE1)
    );

    hp_alarm_mgr #(.THRESH(15), .CW(2)) u2 (
        .CK(CK), .RST(RST), .ARM(ARM), .CLR(CLR), .ALARM_IN(ALARM_IN),
        .FAULT(FAULT2), .FAULT_SRC(FSRC2), .IRQ(IRQ2), .EVT_CNT(CNT2), .STATE(STATE2)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // st: 0 disarmed, 1 arming, 2 monitor, 3 faulted; window tracked by its start cycle
    typedef struct {
        int         st;
        int         arm_t;
        int         win_t;
        int         n;
        logic [1:0] src;
        int         run;
        logic       fault;
        logic [1:0] fsrc;
        logic       irq;
        int         cnt;
        logic [1:0] h1;
        logic [1:0] h2;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 0; m.arm_t = 0; m.win_t = 0; m.n = 0; m.src = 0; m.run = 0;
        m.fault = 0; m.fsrc = 0; m.irq = 0; m.cnt = 0; m.h1 = 0; m.h2 = 0;
        return m;
    endfunction

    task automatic mstep(input mdl_t mi, input int th, input int win, input int adly,
                         input int cw, input logic arm, input logic clr,
                         input logic [1:0] al, input int t, output mdl_t mo);
        mdl_t m;
        logic [1:0] aq, ev;
        int cur;
        bit stk;
        m = mi;
        aq = m.h1;
        ev = m.h1 & ~m.h2;
        m.irq = 0;
        case (m.st)
            0: if (arm) begin m.st = 1; m.arm_t = t; end
            1: if (!arm) m.st = 0; else if (t - m.arm_t == adly) m.st = 2;
            2: begin
                if (!arm) begin
                    m.st = 0; m.n = 0; m.src = 0; m.run = 0;
                end else begin
                    cur = (m.n > 0 && t - m.win_t < win) ? m.n : 0;
                    if (ev != 0) begin
                        if (cur > 0) begin m.n = cur + 1; m.src = m.src | ev; end
                        else begin m.n = 1; m.win_t = t; m.src = ev; end
                        if (m.cnt < (1 << cw) - 1) m.cnt = m.cnt + 1;
                    end else if (cur == 0) begin
                        m.n = 0; m.src = 0;
                    end
                    m.run = (aq != 0) ? m.run + 1 : 0;
                    stk = (m.run >= win - 1);
                    if (m.n >= th || stk) begin
                        m.st = 3; m.fault = 1; m.irq = 1;
                        m.fsrc = stk ? aq : m.src;
                        m.n = 0; m.src = 0; m.run = 0;
                    end
                end
            end
            default: if (clr) begin
                m.fault = 0; m.fsrc = 0;
                if (arm) begin m.st = 1; m.arm_t = t; end else m.st = 0;
            end
        endcase
        if (clr) m.cnt = 0;
        m.h2 = m.h1;
        m.h1 = al;
        mo = m;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        chk("u1.STATE", 32'(STATE1), 32'(m1.st));
        chk("u1.FAULT", 32'(FAULT1), 32'(m1.fault));
        chk("u1.FAULT_SRC", 32'(FSRC1), 32'(m1.fsrc));
        chk("u1.IRQ", 32'(IRQ1), 32'(m1.irq));
        chk("u1.EVT_CNT", 32'(CNT1), 32'(m1.cnt));
        chk("u2.STATE", 32'(STATE2), 32'(m2.st));
        chk("u2.FAULT", 32'(FAULT2), 32'(m2.fault));
        chk("u2.FAULT_SRC", 32'(FSRC2), 32'(m2.fsrc));
        chk("u2.IRQ", 32'(IRQ2), 32'(m2.irq));
        chk("u2.EVT_CNT", 32'(CNT2), 32'(m2.cnt));
    endtask

    task automatic tick();
        mdl_t t1, t2;
        @(posedge CK);
        cyc++;
        mstep(m1, 2, 16, 8, 16, ARM, CLR, ALARM_IN, cyc, t1);
        mstep(m2, 15, 16, 8, 2, ARM, CLR, ALARM_IN, cyc, t2);
        m1 = t1;
        m2 = t2;
        #1;
        check_models();
    endtask

    task automatic pulse(input logic [1:0] mask, input int gap);
        ALARM_IN = mask;
        tick();
        ALARM_IN = 2'b00;
        repeat (gap - 1) tick();
    endtask

    // reset asserted between edges: outputs must drop without waiting for a clock
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b1;
        #1;
        chk({tag, ".STATE"}, 32'(STATE1), 0);
        chk({tag, ".FAULT"}, 32'(FAULT1), 0);
        chk({tag, ".EVT_CNT"}, 32'(CNT1), 0);
        chk({tag, ".IRQ"}, 32'(IRQ1), 0);
        chk({tag, ".u2.EVT_CNT"}, 32'(CNT2), 0);
        m1 = mreset();
        m2 = mreset();
        @(posedge CK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ARM = 1'b0; CLR = 1'b0; ALARM_IN = 2'b00;
        m1 = mreset();
        m2 = mreset();
        #12;
        chk("reset.STATE", 32'(STATE1), 0);
        chk("reset.FAULT", 32'(FAULT1), 0);
        chk("reset.FAULT_SRC", 32'(FSRC1), 0);
        chk("reset.IRQ", 32'(IRQ1), 0);
        chk("reset.EVT_CNT", 32'(CNT1), 0);
        RST = 1'b0;

        // arming delay: exactly 8 cycles in ARMING
        ARM = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("arm.STATE_arming", 32'(STATE1), 1);
        end
        tick();
        chk("arm.STATE_monitor", 32'(STATE1), 2);
        chk("arm.FAULT", 32'(FAULT1), 0);

        // two channel-0 pulses 5 cycles apart
        pulse(2'b01, 5);
        ALARM_IN = 2'b01;
        tick();
        ALARM_IN = 2'b00;
        tick();
        chk("burst.IRQ", 32'(IRQ1), 1);
        chk("burst.FAULT", 32'(FAULT1), 1);
        chk("burst.FAULT_SRC", 32'(FSRC1), 1);
        chk("burst.EVT_CNT", 32'(CNT1), 2);
        tick();
        chk("burst.IRQ_once", 32'(IRQ1), 0);
        chk("burst.STATE", 32'(STATE1), 3);

        // CLR with ARM=1 and a coincident alarm pulse
        CLR = 1'b1; ALARM_IN = 2'b01;
        tick();
        CLR = 1'b0; ALARM_IN = 2'b00;
        chk("clr.FAULT", 32'(FAULT1), 0);
        chk("clr.EVT_CNT", 32'(CNT1), 0);
        chk("clr.STATE", 32'(STATE1), 1);
        repeat (8) tick();
        chk("rearm.STATE", 32'(STATE1), 2);

        // sparse channel-1 pulses never fill a window
        for (int i = 0; i < 3; i++) begin
            pulse(2'b10, 20);
            chk("sparse.EVT_CNT", 32'(CNT1), 32'(i + 1));
            chk("sparse.FAULT", 32'(FAULT1), 0);
        end

        // both channels stuck high
        ALARM_IN = 2'b11;
        repeat (16) tick();
        chk("stuck.FAULT", 32'(FAULT1), 1);
        chk("stuck.FAULT_SRC", 32'(FSRC1), 3);
        chk("stuck.EVT_CNT", 32'(CNT1), 4);
        repeat (3) tick();
        ALARM_IN = 2'b00;
        CLR = 1'b1; ARM = 1'b0;
        tick();
        CLR = 1'b0;
        chk("clr_disarm.STATE", 32'(STATE1), 0);

        // reset mid-arming, then full re-arm and counter saturation on the CW=2 instance
        ARM = 1'b1;
        repeat (3) tick();
        async_reset("rst_arming");
        repeat (9) tick();
        chk("rst_rearm.STATE", 32'(STATE1), 2);
        for (int i = 0; i < 5; i++) pulse(2'b01, 20);
        chk("sat.u2.EVT_CNT", 32'(CNT2), 3);
        chk("sat.u1.EVT_CNT", 32'(CNT1), 5);
        pulse(2'b10, 3);
        async_reset("rst_window");

        // randomized traffic
        ARM = 1'b1;
        begin
            int hold = 0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(199) == 0) ARM = ~ARM;
                CLR = ($urandom_range(39) == 0);
                if (hold > 0) begin
                    hold--;
                end else if ($urandom_range(99) < 8) begin
                    ALARM_IN = 2'($urandom_range(3, 1));
                end else if ($urandom_range(99) == 0) begin
                    ALARM_IN = 2'($urandom_range(3, 1));
                    hold = $urandom_range(20, 8);
                end else begin
                    ALARM_IN = 2'b00;
                end
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
